// File: rtl/idu_stage_pkg.sv
// Shared decode constants and the per-entry decode bundle for idu_stage.
// The o_illegal field exists only when IDU_ILLEGAL_EN is defined.
package idu_stage_pkg;

  localparam logic [3:0] IDU_CLS_OP      = 4'd0;
  localparam logic [3:0] IDU_CLS_OP_IMM  = 4'd1;
  localparam logic [3:0] IDU_CLS_LOAD    = 4'd2;
  localparam logic [3:0] IDU_CLS_STORE   = 4'd3;
  localparam logic [3:0] IDU_CLS_BRANCH  = 4'd4;
  localparam logic [3:0] IDU_CLS_JAL     = 4'd5;
  localparam logic [3:0] IDU_CLS_JALR    = 4'd6;
  localparam logic [3:0] IDU_CLS_LUI     = 4'd7;
  localparam logic [3:0] IDU_CLS_AUIPC   = 4'd8;
  localparam logic [3:0] IDU_CLS_SYS     = 4'd9;
  localparam logic [3:0] IDU_CLS_FENCE   = 4'd10;
  localparam logic [3:0] IDU_CLS_UNKNOWN = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;
  localparam logic [31:0] INS_WFI    = 32'h1050_0073;

  // imm is kept at 32 bits; the top sign-extends it to XLEN on the way out
  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rdid;
    logic [4:0]  rs1id;
    logic [4:0]  rs2id;
    logic        rdwen;
    logic [31:0] imm;
    logic        sysins;
    logic        ecall;
    logic        mret;
`ifdef IDU_ILLEGAL_EN
    logic        illegal;
`endif
  } idu_dec_t;

  localparam int DEC_W = $bits(idu_dec_t);

endpackage

// File: rtl/idu_stage_dec.sv
// Pure combinational RV32I/Zicsr decoder: instruction word -> decode bundle.
// Illegal-encoding detection is built only with IDU_ILLEGAL_EN.
module idu_stage_dec
  import idu_stage_pkg::*;
(
  input  logic [31:0]      ins,
  output logic [DEC_W-1:0] dec
);

  idu_dec_t    d;
  logic [6:0]  opc;
  logic        wb;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;

  assign opc     = ins[6:0];
  assign imm_i   = {{20{ins[31]}}, ins[31:20]};
  assign imm_s   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u   = {ins[31:12], 12'b0};
  assign imm_j   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  // CSR address in [11:0], rs1 field reused as zimm in [16:12]
  assign imm_csr = {15'b0, ins[19:15], ins[31:20]};

  always_comb begin
    d          = '0;
    wb         = 1'b0;
    d.funct3   = ins[14:12];
    d.funct7b5 = ins[30];
    d.rdid     = ins[11:7];
    d.rs1id    = ins[19:15];
    d.sysins   = (opc == OPC_SYS);
    d.ecall    = (ins == INS_ECALL);
    d.mret     = (ins == INS_MRET);
    case (opc)
      OPC_OP:     begin d.cls = IDU_CLS_OP;     d.rs2id = ins[24:20]; wb = 1'b1; end
      OPC_OP_IMM: begin d.cls = IDU_CLS_OP_IMM; d.imm = imm_i; wb = 1'b1; end
      OPC_LOAD:   begin d.cls = IDU_CLS_LOAD;   d.imm = imm_i; wb = 1'b1; end
      OPC_STORE:  begin d.cls = IDU_CLS_STORE;  d.imm = imm_s; d.rs2id = ins[24:20]; d.rdid = '0; end
      OPC_BRANCH: begin d.cls = IDU_CLS_BRANCH; d.imm = imm_b; d.rs2id = ins[24:20]; d.rdid = '0; end
      OPC_JAL:    begin d.cls = IDU_CLS_JAL;    d.imm = imm_j; d.rs1id = '0; wb = 1'b1; end
      OPC_JALR:   begin d.cls = IDU_CLS_JALR;   d.imm = imm_i; wb = 1'b1; end
      OPC_LUI:    begin d.cls = IDU_CLS_LUI;    d.imm = imm_u; d.rs1id = '0; wb = 1'b1; end
      OPC_AUIPC:  begin d.cls = IDU_CLS_AUIPC;  d.imm = imm_u; d.rs1id = '0; wb = 1'b1; end
      OPC_SYS:    begin d.cls = IDU_CLS_SYS;    d.imm = imm_csr; wb = (ins[14:12] != 3'b000); end
      OPC_FENCE:  begin d.cls = IDU_CLS_FENCE;  d.rdid = '0; end
      default:    begin d.cls = IDU_CLS_UNKNOWN; d.rdid = '0; d.rs1id = '0; end
    endcase
`ifdef IDU_ILLEGAL_EN
    d.illegal = (d.cls == IDU_CLS_UNKNOWN)
      || (opc == OPC_OP && ins[31:25] != 7'h00 && ins[31:25] != 7'h20)
      || (opc == OPC_OP && ins[31:25] == 7'h20 && ins[14:12] != 3'b000 && ins[14:12] != 3'b101)
      || (opc == OPC_SYS && ins[14:12] == 3'b100)
      || (opc == OPC_SYS && ins[14:12] == 3'b000 && ins != INS_ECALL && ins != INS_EBREAK
          && ins != INS_MRET && ins != INS_WFI);
    d.rdwen = wb && (d.rdid != 5'd0) && !d.illegal;
`else
    d.rdwen = wb && (d.rdid != 5'd0);
`endif
  end

  assign dec = d;

endmodule

// File: rtl/idu_stage.sv
// Buffered decode stage: decodes on push, queues bundles in a DEPTH-entry FIFO.
// Define IDU_ILLEGAL_EN to add the per-entry o_illegal flag.
module idu_stage
  import idu_stage_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [31:0]      i_ins,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_ins,
  output logic [3:0]       o_class,
  output logic [2:0]       o_funct3,
  output logic             o_funct7b5,
  output logic [4:0]       o_rdid,
  output logic [4:0]       o_rs1id,
  output logic [4:0]       o_rs2id,
  output logic             o_rdwen,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_sysins,
  output logic             o_ecall,
  output logic             o_mret,
`ifdef IDU_ILLEGAL_EN
  output logic             o_illegal,
`endif
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEC_W-1:0] dec_bits;
  idu_dec_t         dec_in, head;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wptr, rptr;
  logic             push, pop;

  idu_dec_t         mem_dec [DEPTH];
  logic [XLEN-1:0]  mem_pc  [DEPTH];
  logic [31:0]      mem_ins [DEPTH];

  idu_stage_dec u_dec (.ins(i_ins), .dec(dec_bits));
  assign dec_in = dec_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // a full queue still accepts when the head leaves the same cycle
  assign o_pre_ready  = i_rst_n && !i_flush && ((count < CNT_W'(DEPTH)) || i_post_ready);
  assign o_post_valid = (count != '0);
  assign push         = i_pre_valid && o_pre_ready;
  assign pop          = o_post_valid && i_post_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (i_flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // storage needs no reset: every output is gated by o_post_valid
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_dec[wptr] <= dec_in;
      mem_pc[wptr]  <= i_pc;
      mem_ins[wptr] <= i_ins;
    end
  end

  assign head       = o_post_valid ? mem_dec[rptr] : '0;
  assign o_pc       = o_post_valid ? mem_pc[rptr]  : '0;
  assign o_ins      = o_post_valid ? mem_ins[rptr] : '0;
  assign o_class    = head.cls;
  assign o_funct3   = head.funct3;
  assign o_funct7b5 = head.funct7b5;
  assign o_rdid     = head.rdid;
  assign o_rs1id    = head.rs1id;
  assign o_rs2id    = head.rs2id;
  assign o_rdwen    = head.rdwen;
  assign o_imm      = XLEN'($signed(head.imm));
  assign o_sysins   = head.sysins;
  assign o_ecall    = head.ecall;
  assign o_mret     = head.mret;
`ifdef IDU_ILLEGAL_EN
  assign o_illegal  = head.illegal;
`endif
  assign o_count    = count;

endmodule

// File: tb/tb_idu_stage.sv
// Randomized bench for idu_stage against a queue-based reference model.
// Checks o_illegal as well when IDU_ILLEGAL_EN is defined.
module tb_idu_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_pre_valid, i_post_ready;
  logic        o_pre_ready, o_post_valid;
  logic [31:0] i_pc, i_ins, o_pc, o_ins, o_imm;
  logic [3:0]  o_class;
  logic [2:0]  o_funct3;
  logic        o_funct7b5, o_rdwen, o_sysins, o_ecall, o_mret;
  logic [4:0]  o_rdid, o_rs1id, o_rs2id;
  logic [1:0]  o_count;
`ifdef IDU_ILLEGAL_EN
  logic        o_illegal;
`endif

  always #5 i_clk = ~i_clk;

  idu_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_pc(i_pc), .i_ins(i_ins),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .o_pc(o_pc), .o_ins(o_ins), .o_class(o_class), .o_funct3(o_funct3),
    .o_funct7b5(o_funct7b5), .o_rdid(o_rdid), .o_rs1id(o_rs1id), .o_rs2id(o_rs2id),
    .o_rdwen(o_rdwen), .o_imm(o_imm), .o_sysins(o_sysins), .o_ecall(o_ecall),
    .o_mret(o_mret),
`ifdef IDU_ILLEGAL_EN
    .o_illegal(o_illegal),
`endif
    .o_count(o_count)
  );

  typedef struct packed {
    logic [31:0] pc, ins;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1, rs2;
    logic        rdwen;
    logic [31:0] imm;
    logic        sys, ecall, mret, ill;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Expected decode, built from the field rules with integer arithmetic
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    int   imm;
    logic wb;
    logic [6:0] f7;
    e = '0; imm = 0; wb = 1'b0; f7 = ins[31:25];
    e.pc = pc; e.ins = ins; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.sys = (ins[6:0] == 7'h73); e.ecall = (ins == 32'h73); e.mret = (ins == 32'h30200073);
    case (ins[6:0])
      7'h33: begin e.cls = 0; wb = 1; end
      7'h13: begin e.cls = 1; wb = 1; imm = $signed(ins) >>> 20; end
      7'h03: begin e.cls = 2; wb = 1; imm = $signed(ins) >>> 20; end
      7'h23: begin e.cls = 3; imm = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]); end
      7'h63: begin e.cls = 4; imm = -4096*int'(ins[31]) + 2048*int'(ins[7])
                                 + 32*int'(ins[30:25]) + 2*int'(ins[11:8]); end
      7'h6F: begin e.cls = 5; wb = 1; imm = -1048576*int'(ins[31]) + 4096*int'(ins[19:12])
                                 + 2048*int'(ins[20]) + 2*int'(ins[30:21]); end
      7'h67: begin e.cls = 6; wb = 1; imm = $signed(ins) >>> 20; end
      7'h37: begin e.cls = 7; wb = 1; imm = int'(ins & 32'hFFFFF000); end
      7'h17: begin e.cls = 8; wb = 1; imm = int'(ins & 32'hFFFFF000); end
      7'h73: begin e.cls = 9; wb = (ins[14:12] != 0); imm = int'(ins[31:20]) + 4096*int'(ins[19:15]); end
      7'h0F: e.cls = 10;
      default: e.cls = 15;
    endcase
    if (e.cls inside {3, 4, 10, 15}) e.rd = 0;
    if (e.cls inside {5, 7, 8, 15}) e.rs1 = 0;
    if (!(e.cls inside {0, 3, 4})) e.rs2 = 0;
    e.ill = (e.cls == 15)
         || (e.cls == 0 && !(f7 inside {7'h00, 7'h20}))
         || (e.cls == 0 && f7 == 7'h20 && !(e.f3 inside {3'd0, 3'd5}))
         || (e.cls == 9 && e.f3 == 3'd4)
         || (e.cls == 9 && e.f3 == 3'd0 && !(ins inside {32'h73, 32'h00100073, 32'h30200073, 32'h10500073}));
`ifdef IDU_ILLEGAL_EN
    if (e.ill) wb = 0;
`endif
    e.rdwen = wb && (e.rd != 0);
    e.imm = 32'(imm);
    return e;
  endfunction

  // One clock: drive, check head/handshake at negedge, advance model, land at posedge+1
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pr, input logic fl);
    exp_t e;
    logic rdy;
    i_pre_valid = pv; i_pc = pc; i_ins = ins; i_post_ready = pr; i_flush = fl;
    @(negedge i_clk);
    e = '0;
    if (q.size() != 0) e = q[0];
    rdy = !fl && (q.size() < DEPTH || pr);
    chk("pre_ready",  64'(o_pre_ready),  64'(rdy));
    chk("post_valid", 64'(o_post_valid), 64'(q.size() != 0));
    chk("count",      64'(o_count),      64'(q.size()));
    chk("pc",     64'(o_pc),       64'(e.pc));
    chk("ins",    64'(o_ins),      64'(e.ins));
    chk("class",  64'(o_class),    64'(e.cls));
    chk("funct3", 64'(o_funct3),   64'(e.f3));
    chk("f7b5",   64'(o_funct7b5), 64'(e.f7b5));
    chk("rdid",   64'(o_rdid),     64'(e.rd));
    chk("rs1id",  64'(o_rs1id),    64'(e.rs1));
    chk("rs2id",  64'(o_rs2id),    64'(e.rs2));
    chk("rdwen",  64'(o_rdwen),    64'(e.rdwen));
    chk("imm",    64'(o_imm),      64'(e.imm));
    chk("sysins", 64'(o_sysins),   64'(e.sys));
    chk("ecall",  64'(o_ecall),    64'(e.ecall));
    chk("mret",   64'(o_mret),     64'(e.mret));
`ifdef IDU_ILLEGAL_EN
    chk("illegal", 64'(o_illegal), 64'(e.ill));
`endif
    if (pr && q.size() != 0) void'(q.pop_front());
    if (fl) q.delete();
    if (pv && rdy) q.push_back(ref_dec(pc, ins));
    @(posedge i_clk); #1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 13))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h73; 10: w[6:0] = 7'h0F;
      11: w = 32'h00000073;
      12: w = 32'h30200073;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_pre_valid = 1'b1; i_post_ready = 1'b1;
    i_pc = 32'h0; i_ins = 32'h00500093;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_pre_ready",  64'(o_pre_ready),  64'(0));
    chk("rst_post_valid", 64'(o_post_valid), 64'(0));
    chk("rst_count",      64'(o_count),      64'(0));
    chk("rst_imm",        64'(o_imm),        64'(0));
    i_rst_n = 1'b1;
    cycle(0, 0, 0, 1, 0);

    // addi x1,x0,5 through an empty queue
    cycle(1, 32'h8000_0000, 32'h00500093, 1, 0);
    chk("addi_valid", 64'(o_post_valid), 64'(1));
    chk("addi_class", 64'(o_class), 64'(1));
    chk("addi_rdid",  64'(o_rdid),  64'(1));
    chk("addi_rs1",   64'(o_rs1id), 64'(0));
    chk("addi_rdwen", 64'(o_rdwen), 64'(1));
    chk("addi_imm",   64'(o_imm),   64'(32'h5));
    chk("addi_count", 64'(o_count), 64'(1));
    cycle(0, 0, 0, 1, 0);
    chk("addi_drain", 64'(o_count), 64'(0));

    cycle(1, 32'h100, 32'hFE20AE23, 1, 0);
    chk("sw_class", 64'(o_class), 64'(3));
    chk("sw_rs1",   64'(o_rs1id), 64'(1));
    chk("sw_rs2",   64'(o_rs2id), 64'(2));
    chk("sw_rdid",  64'(o_rdid),  64'(0));
    chk("sw_rdwen", 64'(o_rdwen), 64'(0));
    chk("sw_imm",   64'(o_imm),   64'(32'hFFFFFFFC));
    cycle(1, 32'h104, 32'hFE000CE3, 1, 0);
    chk("beq_class", 64'(o_class), 64'(4));
    chk("beq_imm",   64'(o_imm),   64'(32'hFFFFFFF8));
    chk("beq_count", 64'(o_count), 64'(1));

    cycle(1, 32'h108, 32'h00000073, 1, 0);
    chk("ecall_sys",   64'(o_sysins), 64'(1));
    chk("ecall_ecall", 64'(o_ecall),  64'(1));
    chk("ecall_mret",  64'(o_mret),   64'(0));
    chk("ecall_rdwen", 64'(o_rdwen),  64'(0));
    cycle(1, 32'h10C, 32'h30200073, 1, 0);
    chk("mret_mret", 64'(o_mret), 64'(1));
    cycle(1, 32'h110, 32'h300312F3, 1, 0);
    chk("csr_addr",  64'(o_imm[11:0]), 64'(12'h300));
    chk("csr_rdwen", 64'(o_rdwen), 64'(1));
    cycle(0, 0, 0, 1, 0);

    // fill to DEPTH, third push refused, then push+pop at full
    cycle(1, 32'h200, 32'h00500093, 0, 0);
    chk("fill_count1", 64'(o_count), 64'(1));
    cycle(1, 32'h204, 32'h00600113, 0, 0);
    chk("fill_count2", 64'(o_count), 64'(2));
    cycle(1, 32'h208, 32'h00700193, 0, 0);
    chk("full_ready", 64'(o_pre_ready), 64'(0));
    cycle(1, 32'h208, 32'h00700193, 1, 0);
    chk("full_pp_count", 64'(o_count), 64'(2));
    chk("full_pp_pc",    64'(o_pc),    64'(32'h204));
    cycle(0, 0, 0, 1, 0);
    chk("drain_pc", 64'(o_pc), 64'(32'h208));
    cycle(0, 0, 0, 1, 0);

    // flush at full with an incoming instruction
    cycle(1, 32'h300, 32'h00500093, 0, 0);
    cycle(1, 32'h304, 32'h00500093, 0, 0);
    cycle(1, 32'h308, 32'h00900093, 0, 1);
    chk("flush_count", 64'(o_count),      64'(0));
    chk("flush_valid", 64'(o_post_valid), 64'(0));
    cycle(0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_ins(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

    // asynchronous reset mid-stream
    cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h400, 32'h00500093, 0, 0);
    cycle(1, 32'h404, 32'h00500093, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_post_valid), 64'(0));
    chk("arst_count", 64'(o_count),      64'(0));
    chk("arst_pc",    64'(o_pc),         64'(0));
    chk("arst_class", 64'(o_class),      64'(0));
    chk("arst_ready", 64'(o_pre_ready),  64'(0));
    q.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    cycle(1, 32'h500, 32'h0000_00B7, 0, 0);
    chk("post_rst_valid", 64'(o_post_valid), 64'(1));
    chk("post_rst_pc",    64'(o_pc),         64'(32'h500));
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
